spram_arbiter: RTL
==================

SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width of requester data and RAM data.
REQ-002 Parameter MEM_DEPTH, default 16, number of RAM words.
REQ-003 Parameter ADDR_WIDTH, default $clog2(MEM_DEPTH), address width.
REQ-004 Parameter MAX_WAIT, default 4, starvation limit in cycles, legal range 1..15.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 wr_req  input  1  write requester asks for the RAM port.
REQ-008 wr_addr  input  ADDR_WIDTH  write address, stable while wr_req=1.
REQ-009 wr_data  input  DATA_WIDTH  write data, stable while wr_req=1.
REQ-010 wr_gnt  output  1  write accepted this cycle.
REQ-011 rd_req  input  1  read requester asks for the RAM port.
REQ-012 rd_addr  input  ADDR_WIDTH  read address, stable while rd_req=1.
REQ-013 rd_gnt  output  1  read accepted this cycle.
REQ-014 rd_valid  output  1  rd_data valid; one-cycle pulse.
REQ-015 rd_data  output  DATA_WIDTH  read result.
REQ-016 ram_cs, ram_we  output  1 each  single-port RAM chip select and write enable.
REQ-017 ram_addr  output  ADDR_WIDTH  RAM address.
REQ-018 ram_wdata  output  DATA_WIDTH  RAM write data.
REQ-019 ram_rdata  input  DATA_WIDTH  RAM read data, valid the cycle after a read access.

Function
REQ-020 wr_gnt and rd_gnt SHALL be combinational from the current requests and arbiter state, and never both 1.
REQ-021 A requester SHALL hold req, addr and data unchanged until the cycle its gnt=1; req may drop the cycle after.
REQ-022 When a grant is issued, ram_cs SHALL be 1; ram_we=wr_gnt; ram_addr/ram_wdata SHALL mux from the granted requester; with no grant ram_cs=0, ram_we=0.
REQ-023 With only one request, that request SHALL be granted in the same cycle (zero-wait).
REQ-024 With both requesting and no starvation override, write SHALL win (baseline fixed priority; see REQ-033).
REQ-025 Each requester SHALL have a wait counter that increments, saturating at MAX_WAIT, on each cycle with req=1 and gnt=0, and clears on grant or when req=0.
REQ-026 A requester whose counter equals MAX_WAIT SHALL win over the other; if both are at MAX_WAIT, the normal policy decides.
REQ-027 rd_valid SHALL be the registered rd_gnt (asserted exactly one cycle after rd_gnt); rd_data SHALL equal ram_rdata while rd_valid=1.
REQ-028 Back-to-back reads SHALL sustain one grant per cycle with rd_valid high every cycle; throughput is one access per cycle total.
REQ-029 A write granted in the cycle after a read grant SHALL NOT corrupt rd_data in that rd_valid cycle.
REQ-030 A read granted in the cycle after a write to the same address SHALL return the new data.

Reset
REQ-031 While rst_n=0, asynchronously: rd_valid=0, both wait counters=0, last-grant register=read; all gnt and ram_cs/ram_we outputs SHALL be 0 regardless of requests.
REQ-032 Reset asserted with a read in flight SHALL drop the pending rd_valid; after release, arbitration SHALL restart from the reset state.

Configuration
REQ-033 Macro SPRAM_ARB_RR_EN: when defined, contention (both requesting, no override) SHALL alternate via a last-grant register, updated on every grant, so the side not granted last wins; when undefined, write always wins per REQ-024 and no last-grant register exists.

Verification
REQ-034 Single write (addr 3, data 0xA5), then read addr 3 -> wr_gnt same cycle; rd_gnt next cycle; rd_valid one cycle later with rd_data=0xA5.
REQ-035 Both requesting continuously, macro undefined, MAX_WAIT=4 -> write granted 4 cycles, read granted 5th cycle, pattern repeats.
REQ-036 Both requesting continuously, SPRAM_ARB_RR_EN defined -> grants alternate W,R,W,R starting with write after reset.
REQ-037 Reads to addr 1,2,3 back-to-back holding 0x11,0x22,0x33 -> rd_valid high 3 consecutive cycles with data 0x11,0x22,0x33.
REQ-038 Read granted, rst_n pulsed low before the next edge -> rd_valid stays 0, counters 0, outputs idle; first post-reset contended grant follows reset policy.

Source files
------------

// File: rtl/spram_arbiter_if.sv
// ---------------------------------------------------------------------------
// spram_arbiter_if
//
// Purpose:
//   Bundles everything the single-port RAM arbiter talks to apart from clock
//   and reset: the write requester, the read requester and the RAM port.
//
// Parameters:
//   DATA_WIDTH  word width of requester data and RAM data
//   ADDR_WIDTH  RAM address width
//
// Signals:
//   wr_req / wr_addr / wr_data   write request, held until wr_gnt
//   wr_gnt                       write accepted this cycle
//   rd_req / rd_addr             read request, held until rd_gnt
//   rd_gnt                       read accepted this cycle
//   rd_valid / rd_data           read result, one cycle after rd_gnt
//   ram_cs / ram_we              RAM chip select / write enable
//   ram_addr / ram_wdata         RAM address / write data
//   ram_rdata                    RAM read data, valid the cycle after a read
//
// Modports:
//   slave   the arbiter itself
//   master  the environment: both requesters plus the RAM macro
// ---------------------------------------------------------------------------
interface spram_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);

    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_gnt;

    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  ram_cs;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport slave (
        input  wr_req, wr_addr, wr_data,
        input  rd_req, rd_addr,
        input  ram_rdata,
        output wr_gnt, rd_gnt, rd_valid, rd_data,
        output ram_cs, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output wr_req, wr_addr, wr_data,
        output rd_req, rd_addr,
        output ram_rdata,
        input  wr_gnt, rd_gnt, rd_valid, rd_data,
        input  ram_cs, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/spram_arbiter.sv
// ---------------------------------------------------------------------------
// spram_arbiter
//
// Purpose:
//   Shares one single-port RAM between a write requester and a read
//   requester. Grants are combinational (zero-wait when uncontended), at most
//   one access per cycle. Under contention the write side wins, unless the
//   read side has waited MAX_WAIT cycles, in which case the starved side wins.
//   Read data is returned one cycle after the read grant with rd_valid.
//
// Optional feature (macro SPRAM_ARB_RR_EN):
//   When defined, contention without a starvation override alternates between
//   the two sides using a last-grant register (the side not granted last
//   wins). When undefined, write always wins and no last-grant register exists.
//
// Parameters:
//   DATA_WIDTH  word width (default 8)
//   MEM_DEPTH   number of RAM words (default 16)
//   ADDR_WIDTH  address width (default $clog2(MEM_DEPTH))
//   MAX_WAIT    starvation limit in cycles, 1..15 (default 4)
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    spram_arbiter_if.slave: requesters and RAM port
// ---------------------------------------------------------------------------
module spram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int MAX_WAIT   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    spram_arbiter_if.slave    bus
);

    // Elaboration-time sanity check: the wait counters are 4 bits wide and
    // the address must be able to reach every RAM word.
    if (MAX_WAIT < 1 || MAX_WAIT > 15 || (1 << ADDR_WIDTH) < MEM_DEPTH) begin : g_bad_params
        $error("spram_arbiter: MAX_WAIT must be 1..15 and ADDR_WIDTH must cover MEM_DEPTH");
    end

    typedef logic [3:0] wait_cnt_t;

    localparam wait_cnt_t WAIT_LIMIT = wait_cnt_t'(MAX_WAIT);

    wait_cnt_t wr_wait;
    wait_cnt_t rd_wait;

    logic wr_starved;
    logic rd_starved;
    logic wr_win;
    logic rd_win;
    logic wr_gnt;
    logic rd_gnt;
    logic rd_valid;

`ifdef SPRAM_ARB_RR_EN
    typedef enum logic {
        LAST_RD = 1'b0,
        LAST_WR = 1'b1
    } last_gnt_t;

    last_gnt_t last_gnt;
`endif

    // A side only counts as starved while it is actually requesting; the
    // counter itself already clears whenever the request drops.
    assign wr_starved = bus.wr_req && (wr_wait == WAIT_LIMIT);
    assign rd_starved = bus.rd_req && (rd_wait == WAIT_LIMIT);

    // Arbitration decision. A lone request always wins at once. Under
    // contention a starved side overrides the normal policy; if both or
    // neither are starved the normal policy (fixed write priority, or
    // alternation when the round-robin option is built in) decides.
    always_comb begin
        wr_win = 1'b0;
        rd_win = 1'b0;
        if (bus.wr_req && bus.rd_req) begin
            if (wr_starved && !rd_starved) begin
                wr_win = 1'b1;
            end else if (rd_starved && !wr_starved) begin
                rd_win = 1'b1;
            end else begin
`ifdef SPRAM_ARB_RR_EN
                if (last_gnt == LAST_RD) begin
                    wr_win = 1'b1;
                end else begin
                    rd_win = 1'b1;
                end
`else
                wr_win = 1'b1;
`endif
            end
        end else if (bus.wr_req) begin
            wr_win = 1'b1;
        end else if (bus.rd_req) begin
            rd_win = 1'b1;
        end
    end

    // Grants are forced low while reset is held, independent of requests,
    // so nothing reaches the RAM during reset.
    assign wr_gnt = rst_n && wr_win;
    assign rd_gnt = rst_n && rd_win;

    // Write wait counter: counts cycles spent requesting without a grant,
    // saturating at the starvation limit; any grant or idle cycle clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_wait <= '0;
        end else if (bus.wr_req && !wr_gnt) begin
            if (wr_wait != WAIT_LIMIT) begin
                wr_wait <= wr_wait + wait_cnt_t'(1);
            end
        end else begin
            wr_wait <= '0;
        end
    end

    // Read wait counter, same behaviour as the write side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_wait <= '0;
        end else if (bus.rd_req && !rd_gnt) begin
            if (rd_wait != WAIT_LIMIT) begin
                rd_wait <= rd_wait + wait_cnt_t'(1);
            end
        end else begin
            rd_wait <= '0;
        end
    end

`ifdef SPRAM_ARB_RR_EN
    // Last-grant register: remembers which side was served most recently so
    // that the other side wins the next plain contention. Resetting to read
    // makes the first contended grant after reset go to the write side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= LAST_RD;
        end else if (wr_gnt) begin
            last_gnt <= LAST_WR;
        end else if (rd_gnt) begin
            last_gnt <= LAST_RD;
        end
    end
`endif

    // The RAM returns read data one cycle after the access, so rd_valid is
    // simply the registered read grant. Asynchronous reset kills a pending
    // read result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_gnt;
        end
    end

    // RAM port mux. A write in the cycle after a read does not disturb the
    // read result because the RAM only updates its read data on read
    // accesses; a read right after a write sees the freshly written word.
    assign bus.ram_cs    = wr_gnt || rd_gnt;
    assign bus.ram_we    = wr_gnt;
    assign bus.ram_addr  = wr_gnt ? bus.wr_addr
                         : rd_gnt ? bus.rd_addr
                         : {ADDR_WIDTH{1'b0}};
    assign bus.ram_wdata = wr_gnt ? bus.wr_data : {DATA_WIDTH{1'b0}};

    assign bus.wr_gnt    = wr_gnt;
    assign bus.rd_gnt    = rd_gnt;
    assign bus.rd_valid  = rd_valid;
    assign bus.rd_data   = rd_valid ? bus.ram_rdata : {DATA_WIDTH{1'b0}};

endmodule
